hxdp_maps_port_arbiter: RTL and testbench
=========================================

Name: hxdp_maps_port_arbiter

Overview:
- Sits directly downstream of the host register block's map-memory write outputs (128-bit line, 32-bit address, single-cycle write-enable pulse).
- Also sits beside the Sephirot datapath map-access port.
- Merges both onto one single-port map BRAM: a host write FIFO absorbs register-side pulses while the datapath holds priority, and idle cycles refresh a host read-back word.

Parameters:
DATA_W, 128, map line width
ADDR_W, 8, map line address width (low bits of host 32-bit address used)
FIFO_DEPTH, 4, host write FIFO entries, power of 2, >=2
MAX_WAIT, 16, starvation guard threshold in cycles (used only with guard macro)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
host_we  in  1  host write pulse
host_addr  in  32  host line address; bits [ADDR_W-1:0] used
host_wdata  in  DATA_W  host line data
host_rd_addr  in  ADDR_W  address for background host read-back
host_rdata  out  DATA_W  last read-back word
host_rdata_valid  out  1  pulse when host_rdata updated
dp_req  in  1  datapath access request (held until granted)
dp_we  in  1  datapath write (else read)
dp_addr  in  ADDR_W  datapath address
dp_wdata  in  DATA_W  datapath write data
dp_gnt  out  1  combinational grant this cycle
dp_rvalid  out  1  datapath read data valid
dp_rdata  out  DATA_W  datapath read data
mem_en  out  1  BRAM enable
mem_we  out  1  BRAM write enable
mem_addr  out  ADDR_W  BRAM address
mem_wdata  out  DATA_W  BRAM write data
mem_rdata  in  DATA_W  BRAM read data, 1-cycle latency
fifo_full  out  1  host FIFO full
overflow_cnt  out  16  dropped host writes, saturating

Behaviour:
- Reset (async assert, sync release): FIFO empty, all pointers zero; host_rdata=0, host_rdata_valid=0, dp_rvalid=0, dp_rdata=0, overflow_cnt=0, wait counter 0; memory port outputs combinational and inactive (mem_en=0, mem_we=0).
- Enqueue: host_we=1 and not full -> push {host_addr[ADDR_W-1:0], host_wdata}.
- host_we=1 while full -> write dropped; overflow_cnt+1, saturating at 16'hFFFF.
- Push and pop in the same cycle with FIFO full: push still rejected, because full is evaluated before the pop.
- Arbiter, one grant per cycle:
  - priority 1: dp_req (dp_gnt=1; memory port driven from dp_*);
  - priority 2: FIFO non-empty (head write issued, popped that cycle);
  - priority 3: idle (read at host_rd_addr issued, mem_en=1, mem_we=0).
- Tag pipeline: registered 2-bit slot tag {NONE, DP_RD, HOST_RD} tracks the issued read.
  - Next cycle, if tag is DP_RD: dp_rvalid=1 and dp_rdata=mem_rdata.
  - Next cycle, if tag is HOST_RD: host_rdata_valid=1 and host_rdata=mem_rdata.
  - Datapath writes produce no dp_rvalid.
- Read latency: exactly 1 cycle from grant to valid. Back-to-back datapath reads sustain 1 per cycle.
- Wrap-around: pointers are log2(FIFO_DEPTH)+1 bits wide. Full when MSBs differ and the rest are equal; empty when the pointers are equal.
- Ordering: host writes are committed in arrival order. A datapath write and a host write to the same address resolve by grant order.
- Reset mid-operation: queued host writes are discarded, in-flight read tags are cleared, and no valid is emitted after reset.

Optional Feature:
- Macro HXDP_MAPARB_STARVE_GUARD_EN.
- With it:
  - a wait counter increments each cycle the FIFO is non-empty and dp_gnt=1;
  - on reaching MAX_WAIT, the next cycle grants the FIFO head over dp_req (dp_gnt=0) and the counter clears;
  - the counter also clears on any FIFO pop.
- Without it: strict datapath priority; no counter logic.

Decomposition:
- Package hxdp_maps_pkg: slot tag enum (NONE, DP_RD, HOST_RD), DATA_W/ADDR_W defaults, overflow counter width constant.
- One sub-module: hxdp_sync_fifo (parameterised width/depth, full/empty, async reset) holding host write entries.

Test Plan:
- Reset, then host_we with addr 0x05, data 128'hA5..A5, dp_req=0 -> next cycle mem_we=1, mem_addr=0x05, mem_wdata=A5..A5; FIFO empty after.
- dp_req held 10 cycles with dp_we=0, addr 0x10, plus 6 host_we pulses -> dp_rvalid each cycle with 1-cycle latency; 4 queued, overflow_cnt=2, fifo_full=1; after dp_req drops, 4 writes committed in order.
- Idle, host_rd_addr=0x22, BRAM holds 0xDEAD at 0x22 -> host_rdata_valid pulses every cycle, host_rdata=0xDEAD.
- Assert rst asynchronously with FIFO holding 3 entries and a DP_RD in flight -> no dp_rvalid next edge, no mem_we after release, overflow_cnt=0.
- With HXDP_MAPARB_STARVE_GUARD_EN and MAX_WAIT=16: dp_req constant, one host write queued -> host write granted on the 17th cycle with dp_gnt=0 that cycle.
- Force overflow_cnt to 0xFFFE, then 3 drops -> counter stays at 0xFFFF.

Source files
------------

// File: rtl/hxdp_maps_pkg.sv
// rtl/hxdp_maps_pkg.sv - shared types and defaults for the map-port arbiter
package hxdp_maps_pkg;
  localparam int DATA_W_DEF = 128;
  localparam int ADDR_W_DEF = 8;
  localparam int OVF_W      = 16;

  // Identifies which requester owns the read issued in the previous cycle
  typedef enum logic [1:0] {
    SLOT_NONE    = 2'd0,
    SLOT_DP_RD   = 2'd1,
    SLOT_HOST_RD = 2'd2
  } slot_tag_e;
endpackage

// File: rtl/hxdp_sync_fifo.sv
// rtl/hxdp_sync_fifo.sv - synchronous FIFO, extra-MSB pointers, full checked before pop
module hxdp_sync_fifo #(
  parameter int WIDTH = 136,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage needs no reset: pointers alone define validity
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/hxdp_maps_port_arbiter.sv
// rtl/hxdp_maps_port_arbiter.sv - merges datapath and host writes onto one map BRAM port
// Optional starvation guard for queued host writes: HXDP_MAPARB_STARVE_GUARD_EN
module hxdp_maps_port_arbiter
  import hxdp_maps_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_we,
  input  logic [31:0]       host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rdata_valid,
  input  logic              dp_req,
  input  logic              dp_we,
  input  logic [ADDR_W-1:0] dp_addr,
  input  logic [DATA_W-1:0] dp_wdata,
  output logic              dp_gnt,
  output logic              dp_rvalid,
  output logic [DATA_W-1:0] dp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fifo_full,
  output logic [15:0]       overflow_cnt
);
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [ENT_W-1:0]  fifo_dout;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              force_host;
  logic              grant_dp;
  logic              grant_host;
  slot_tag_e         tag_q, tag_d;
  logic [DATA_W-1:0] dp_rdata_q, dp_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic [OVF_W-1:0]  overflow_q, overflow_d;
  logic              unused_host_addr;

  assign unused_host_addr = ^host_addr[31:ADDR_W];

  hxdp_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_host_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (host_we),
    .pop   (fifo_pop),
    .din   ({host_addr[ADDR_W-1:0], host_wdata}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef HXDP_MAPARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;

  assign force_host = !fifo_empty && (wait_q == WAIT_W'(MAX_WAIT));

  always_comb begin
    wait_d = wait_q;
    if (fifo_pop) begin
      wait_d = '0;
    end else if (!fifo_empty && dp_gnt && (wait_q != WAIT_W'(MAX_WAIT))) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end
`else
  assign force_host = 1'b0;
`endif

  assign grant_dp   = dp_req && !force_host;
  assign grant_host = !grant_dp && !fifo_empty;
  assign dp_gnt     = grant_dp && !rst;
  assign fifo_pop   = grant_host && !rst;

  // Idle cycles are never wasted: they refresh the host read-back word
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_d     = SLOT_NONE;
    if (!rst) begin
      mem_en = 1'b1;
      if (grant_dp) begin
        mem_we    = dp_we;
        mem_addr  = dp_addr;
        mem_wdata = dp_wdata;
        tag_d     = dp_we ? SLOT_NONE : SLOT_DP_RD;
      end else if (grant_host) begin
        mem_we    = 1'b1;
        mem_addr  = fifo_dout[ENT_W-1:DATA_W];
        mem_wdata = fifo_dout[DATA_W-1:0];
      end else begin
        mem_addr  = host_rd_addr;
        tag_d     = SLOT_HOST_RD;
      end
    end
  end

  assign dp_rvalid        = (tag_q == SLOT_DP_RD);
  assign host_rdata_valid = (tag_q == SLOT_HOST_RD);
  assign dp_rdata_d       = dp_rvalid ? mem_rdata : dp_rdata_q;
  assign host_rdata_d     = host_rdata_valid ? mem_rdata : host_rdata_q;
  assign dp_rdata         = dp_rdata_d;
  assign host_rdata       = host_rdata_d;
  assign overflow_cnt     = overflow_q;

  always_comb begin
    overflow_d = overflow_q;
    if (host_we && fifo_full && (overflow_q != {OVF_W{1'b1}})) begin
      overflow_d = overflow_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q        <= SLOT_NONE;
      dp_rdata_q   <= '0;
      host_rdata_q <= '0;
      overflow_q   <= '0;
    end else begin
      tag_q        <= tag_d;
      dp_rdata_q   <= dp_rdata_d;
      host_rdata_q <= host_rdata_d;
      overflow_q   <= overflow_d;
    end
  end
endmodule

// File: tb/tb_hxdp_maps_port_arbiter.sv
// tb/tb_hxdp_maps_port_arbiter.sv - scoreboard bench for the map-port arbiter
module tb_hxdp_maps_port_arbiter;
  localparam logic [127:0] V10  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] DEAD = 128'hDEAD;
  localparam logic [127:0] A5   = {16{8'hA5}};
  localparam logic [127:0] X40  = {4{32'hBEEF_CAFE}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         host_we;
  logic [31:0]  host_addr;
  logic [127:0] host_wdata;
  logic [7:0]   host_rd_addr;
  logic [127:0] host_rdata;
  logic         host_rdata_valid;
  logic         dp_req, dp_we;
  logic [7:0]   dp_addr;
  logic [127:0] dp_wdata;
  logic         dp_gnt, dp_rvalid;
  logic [127:0] dp_rdata;
  logic         mem_en, mem_we;
  logic [7:0]   mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         fifo_full;
  logic [15:0]  overflow_cnt;

  typedef struct packed {
    logic [7:0]   a;
    logic [127:0] d;
  } wr_t;

  wr_t          wr_q [$];
  logic [127:0] rd_q [$];
  logic [127:0] hr_q [$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] bram [256];

  always #5 clk = ~clk;

  hxdp_maps_port_arbiter #(
    .DATA_W(128), .ADDR_W(8), .FIFO_DEPTH(4), .MAX_WAIT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rd_addr(host_rd_addr), .host_rdata(host_rdata), .host_rdata_valid(host_rdata_valid),
    .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
    .dp_gnt(dp_gnt), .dp_rvalid(dp_rvalid), .dp_rdata(dp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fifo_full(fifo_full), .overflow_cnt(overflow_cnt)
  );

  // Single-port BRAM, read-first, one cycle read latency
  always @(posedge clk) begin
    if (rst) begin
      bram[8'h10] <= V10;
      bram[8'h22] <= DEAD;
      mem_rdata   <= '0;
    end else if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
    end
  end

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got an output event, expected none", name);
  endfunction

  function automatic logic [127:0] hd(input logic [7:0] a);
    return {4{24'hC0FFEE, a}};
  endfunction

  always @(negedge clk) begin : monitor
    wr_t          e;
    logic [127:0] r;
    if (mem_en && mem_we) begin
      if (wr_q.size() == 0) unexpected("mem_write");
      else begin
        e = wr_q.pop_front();
        chk("wr_addr", 128'(mem_addr), 128'(e.a));
        chk("wr_data", mem_wdata, e.d);
      end
    end
    if (dp_rvalid) begin
      if (rd_q.size() == 0) unexpected("dp_rvalid");
      else begin
        r = rd_q.pop_front();
        chk("dp_rdata", dp_rdata, r);
      end
    end
    if (host_rdata_valid && hr_q.size() != 0) begin
      r = hr_q.pop_front();
      chk("host_rdata", host_rdata, r);
    end
  end

  task automatic drive(input logic dq, input logic dw, input logic [7:0] da, input logic [127:0] dd,
                       input logic hw, input logic [7:0] ha, input logic [127:0] hdat);
    dp_req     = dq;
    dp_we      = dw;
    dp_addr    = da;
    dp_wdata   = dd;
    host_we    = hw;
    host_addr  = {24'h0, ha};
    host_wdata = hdat;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, 8'h00, '0, 1'b0, 8'h00, '0);
  endtask

  initial begin : watchdog
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : stim
    idle();
    host_rd_addr = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en", 128'(mem_en), 128'(0));
    chk("rst_mem_we", 128'(mem_we), 128'(0));
    chk("rst_dp_gnt", 128'(dp_gnt), 128'(0));
    chk("rst_dp_rvalid", 128'(dp_rvalid), 128'(0));
    chk("rst_host_valid", 128'(host_rdata_valid), 128'(0));
    chk("rst_host_rdata", host_rdata, 128'(0));
    chk("rst_dp_rdata", dp_rdata, 128'(0));
    chk("rst_fifo_full", 128'(fifo_full), 128'(0));
    chk("rst_overflow", 128'(overflow_cnt), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // single host write, committed the next cycle
    drive(1'b0, 1'b0, 8'h00, '0, 1'b1, 8'h05, A5);
    wr_q.push_back('{a: 8'h05, d: A5});
    tick();
    idle();
    #1;
    chk("a_mem_we", 128'(mem_we), 128'(1));
    chk("a_dp_gnt", 128'(dp_gnt), 128'(0));
    tick();
    chk("a_wr_drained", 128'(wr_q.size()), 128'(0));
    chk("a_mem_we_after", 128'(mem_we), 128'(0));

    // datapath reads held 10 cycles while 6 host pulses arrive
    for (int c = 0; c < 10; c++) begin
      if (c == 6) begin
        chk("b_fifo_full", 128'(fifo_full), 128'(1));
        chk("b_overflow", 128'(overflow_cnt), 128'(2));
      end
      drive(1'b1, 1'b0, 8'h10, '0, c < 6, 8'(8'h30 + c), hd(8'(8'h30 + c)));
      if (c < 4) wr_q.push_back('{a: 8'(8'h30 + c), d: hd(8'(8'h30 + c))});
      rd_q.push_back(V10);
      #1;
      chk("b_dp_gnt", 128'(dp_gnt), 128'(1));
      tick();
    end
    idle();
    repeat (6) tick();
    chk("b_wr_drained", 128'(wr_q.size()), 128'(0));
    chk("b_rd_drained", 128'(rd_q.size()), 128'(0));
    chk("b_fifo_not_full", 128'(fifo_full), 128'(0));

    // datapath write then back-to-back reads
    drive(1'b1, 1'b1, 8'h40, X40, 1'b0, 8'h00, '0);
    wr_q.push_back('{a: 8'h40, d: X40});
    #1;
    chk("c_dp_gnt_wr", 128'(dp_gnt), 128'(1));
    tick();
    drive(1'b1, 1'b0, 8'h40, '0, 1'b0, 8'h00, '0); rd_q.push_back(X40); tick();
    drive(1'b1, 1'b0, 8'h10, '0, 1'b0, 8'h00, '0); rd_q.push_back(V10); tick();
    drive(1'b1, 1'b0, 8'h40, '0, 1'b0, 8'h00, '0); rd_q.push_back(X40); tick();
    idle();
    repeat (2) tick();
    chk("c_rd_drained", 128'(rd_q.size()), 128'(0));
    chk("c_wr_drained", 128'(wr_q.size()), 128'(0));

    // background host read-back on idle cycles
    host_rd_addr = 8'h22;
    tick();
    repeat (5) hr_q.push_back(DEAD);
    repeat (5) tick();
    chk("h_drained", 128'(hr_q.size()), 128'(0));
    chk("h_rdata", host_rdata, DEAD);

    // reset with 3 queued writes and a datapath read in flight
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 8'h10, '0, 1'b1, 8'(8'h50 + c), hd(8'(8'h50 + c)));
      if (c < 2) rd_q.push_back(V10);
      tick();
    end
    rst = 1'b1;
    idle();
    #1;
    chk("d_no_rvalid", 128'(dp_rvalid), 128'(0));
    chk("d_overflow", 128'(overflow_cnt), 128'(0));
    chk("d_host_rdata", host_rdata, 128'(0));
    chk("d_fifo_full", 128'(fifo_full), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) tick();
    chk("d_rd_drained", 128'(rd_q.size()), 128'(0));
    chk("d_overflow_after", 128'(overflow_cnt), 128'(0));

`ifdef HXDP_MAPARB_STARVE_GUARD_EN
    drive(1'b1, 1'b0, 8'h10, '0, 1'b1, 8'h60, hd(8'h60));
    wr_q.push_back('{a: 8'h60, d: hd(8'h60)});
    rd_q.push_back(V10);
    tick();
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 1'b0, 8'h10, '0, 1'b0, 8'h00, '0);
      #1;
      if (i < 17) begin
        chk("e_dp_gnt", 128'(dp_gnt), 128'(1));
        rd_q.push_back(V10);
      end else begin
        chk("e_dp_gnt_starve", 128'(dp_gnt), 128'(0));
        chk("e_mem_we_starve", 128'(mem_we), 128'(1));
      end
      tick();
    end
    idle();
    repeat (3) tick();
    chk("e_wr_drained", 128'(wr_q.size()), 128'(0));
    chk("e_rd_drained", 128'(rd_q.size()), 128'(0));
`endif

    // saturating overflow counter
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b0, 8'h10, '0, 1'b1, 8'(8'h70 + c), hd(8'(8'h70 + c)));
      wr_q.push_back('{a: 8'(8'h70 + c), d: hd(8'(8'h70 + c))});
      rd_q.push_back(V10);
      tick();
    end
    chk("f_fifo_full", 128'(fifo_full), 128'(1));
    drive(1'b1, 1'b0, 8'h10, '0, 1'b0, 8'h00, '0);
    rd_q.push_back(V10);
    force dut.overflow_q = 16'hFFFE;
    tick();
    release dut.overflow_q;
    #1;
    chk("f_overflow_preset", 128'(overflow_cnt), 128'(16'hFFFE));
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b0, 8'h10, '0, 1'b1, 8'h7C, hd(8'h7C));
      rd_q.push_back(V10);
      tick();
      chk("f_overflow_sat", 128'(overflow_cnt), 128'(16'hFFFF));
    end
    idle();
    repeat (6) tick();
    chk("f_wr_drained", 128'(wr_q.size()), 128'(0));
    chk("f_rd_drained", 128'(rd_q.size()), 128'(0));
    chk("f_overflow_hold", 128'(overflow_cnt), 128'(16'hFFFF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
